// File: rtl/delay_line_meter.sv
`timescale 1ns/1ps
// Round-trip delay meter: toggles inR, times the synchronized echo on outR over
// 2^LOG_RUNS runs and reports the sum, minimum and maximum per-run cycle counts.
module delay_line_meter #(
  parameter int CNT_W    = 16,
  parameter int LOG_RUNS = 2,
  parameter int TMO_CYC  = 1000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  output logic                      inR,
  input  logic                      outR,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic [CNT_W+LOG_RUNS-1:0] sum_cycles,
  output logic [CNT_W-1:0]          min_cycles,
  output logic [CNT_W-1:0]          max_cycles,
  output logic [2:0]                dbg_state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int SUM_W = CNT_W + LOG_RUNS;

  // SETTLE gives up after TMO_CYC cycles; WAIT gives up so that DONE lands
  // exactly TMO_CYC cycles after the LAUNCH cycle.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TMO_CYC - 2);

  logic [2:0]          state_q, state_d;
  logic                inr_q, inr_d;
  logic                s1_q, s2_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LOG_RUNS-1:0] run_q, run_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0]    min_q, min_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic                tmo_q, tmo_d;
  logic                match;

  assign match = (s2_q == inr_q);

  always_comb begin
    state_d = state_q;
    inr_d   = inr_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: ;
      S_SETTLE: begin
        if (match) begin
          state_d = S_LAUNCH;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LAUNCH: begin
        inr_d   = ~inr_q;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // cnt_q counts the edges since the toggle on which s2 still lagged.
        if (match) begin
          sum_d = sum_q + SUM_W'(cnt_q);
          if (cnt_q < min_q) min_d = cnt_q;
          if (cnt_q > max_q) max_d = cnt_q;
          run_d   = run_q + LOG_RUNS'(1);
          state_d = (run_d == '0) ? S_DONE : S_LAUNCH;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d = S_SETTLE;
      tmo_d   = 1'b0;
      sum_d   = '0;
      min_d   = '1;
      max_d   = '0;
      run_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      inr_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      run_q   <= '0;
      sum_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inr_q   <= inr_d;
      s1_q    <= outR;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      tmo_q   <= tmo_d;
    end
  end

  assign inR         = inr_q;
  assign busy        = (state_q == S_SETTLE) || (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign done        = (state_q == S_DONE);
  assign timeout     = tmo_q;
  assign sum_cycles  = sum_q;
  assign min_cycles  = min_q;
  assign max_cycles  = max_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_delay_line_meter.sv
`timescale 1ns/1ps
// Bench for delay_line_meter: a delay-line model on outR, a result scoreboard
// fed by the driver tasks, plus a second instance with a short timeout.
module tb_delay_line_meter;
  localparam int CNT_W    = 16;
  localparam int LOG_RUNS = 2;
  localparam int RUNS     = 1 << LOG_RUNS;
  localparam int SW       = CNT_W + LOG_RUNS;
  localparam int EW       = 2 + SW + 2 * CNT_W;
  localparam int TMO_T    = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // main instance with a modelled delay line
  logic start = 1'b0;
  logic inR, outR, busy, done, timeout;
  logic [SW-1:0] sum_cycles;
  logic [CNT_W-1:0] min_cycles, max_cycles;
  logic [2:0] dbg_state;
  logic outr_dly = 1'b0;
  int dly_ns = 0;

  always @(inR) begin
    #(dly_ns);
    outr_dly = inR;
  end
  assign outR = (dly_ns == 0) ? inR : outr_dly;

  delay_line_meter #(.CNT_W(CNT_W), .LOG_RUNS(LOG_RUNS), .TMO_CYC(1000)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .inR(inR), .outR(outR),
    .busy(busy), .done(done), .timeout(timeout), .sum_cycles(sum_cycles),
    .min_cycles(min_cycles), .max_cycles(max_cycles), .dbg_state_o(dbg_state)
  );

  // short-timeout instance with a dead delay line
  logic start_t = 1'b0;
  logic inR_t, busy_t, done_t, timeout_t;
  logic [SW-1:0] sum_t;
  logic [CNT_W-1:0] min_t, max_t;
  logic [2:0] dbg_state_t;

  delay_line_meter #(.CNT_W(CNT_W), .LOG_RUNS(LOG_RUNS), .TMO_CYC(TMO_T)) u_tmo (
    .clk(clk), .rstn(rstn), .start(start_t), .inR(inR_t), .outR(1'b0),
    .busy(busy_t), .done(done_t), .timeout(timeout_t), .sum_cycles(sum_t),
    .min_cycles(min_t), .max_cycles(max_t), .dbg_state_o(dbg_state_t)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Echo reaches s1 on the first edge after the line delay, s2 one edge later.
  function automatic logic [EW-1:0] model(input int d);
    int s;
    s = d / 10 + 2;
    return {1'b0, 1'b0, SW'(RUNS * s), CNT_W'(s), CNT_W'(s)};
  endfunction

  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rstn && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("done_inR", inR, e[EW-1]);
          check("done_timeout", timeout, e[EW-2]);
          check("done_sum", sum_cycles, e[2*CNT_W +: SW]);
          check("done_min", min_cycles, e[CNT_W +: CNT_W]);
          check("done_max", max_cycles, e[0 +: CNT_W]);
          check("done_busy", busy, 0);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_wait actual=none required=done within %0d cycles", budget);
    end
  endtask

  task automatic run_meas(input int d, input bit noise);
    int cyc;
    logic [EW-1:0] e;
    dly_ns = d;
    e = model(d);
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (noise) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(400, cyc);
    @(negedge clk);
    check("done_single", done, 0);
    check("sum_hold", sum_cycles, e[2*CNT_W +: SW]);
  endtask

  task automatic back_to_back(input int d);
    int cyc;
    dly_ns = d;
    exp_q.push_back(model(d));
    exp_q.push_back(model(d));
    start = 1'b1;
    @(negedge clk);
    check("b2b_busy_first", busy, 1);
    wait_done(400, cyc);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_second", busy, 1);
    check("b2b_done_low", done, 0);
    wait_done(400, cyc);
    @(negedge clk);
  endtask

  task automatic reset_mid(input int d, input int toggles);
    int n;
    int cyc;
    logic prev;
    dly_ns = d;
    exp_q.push_back(model(d));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    cyc = 0;
    prev = inR;
    while (n < toggles && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (inR != prev) begin
        n++;
        prev = inR;
      end
    end
    check("rst_toggles_seen", n, toggles);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    exp_q.delete();
    check("rst_inR", inR, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_sum", sum_cycles, 0);
    check("rst_min", min_cycles, 0);
    check("rst_max", max_cycles, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic tmo_meas(input int exp_lat);
    int cyc;
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    check("tmo_busy_after_start", busy_t, 1);
    check("tmo_flag_cleared", timeout_t, 0);
    cyc = 0;
    while (!done_t && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_latency", cyc, exp_lat);
    check("tmo_flag", timeout_t, 1);
    check("tmo_busy_in_done", busy_t, 0);
    @(negedge clk);
    check("tmo_done_single", done_t, 0);
    check("tmo_flag_held", timeout_t, 1);
  endtask

  initial begin : driver
    int tbl[5];
    int d;
    tbl = '{0, 13, 27, 35, 48};
    repeat (2) @(negedge clk);
    #1;
    check("reset_inR", inR, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_timeout", timeout, 0);
    check("reset_sum", sum_cycles, 0);
    check("reset_min", min_cycles, 0);
    check("reset_max", max_cycles, 0);
    check("reset_state", dbg_state, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    run_meas(0, 1'b0);
    run_meas(35, 1'b0);
    for (int i = 0; i < 12; i++) begin
      d = tbl[$urandom_range(0, 4)];
      run_meas(d, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    back_to_back(0);
    back_to_back(27);
    reset_mid(0, 2);
    run_meas(0, 1'b0);
    reset_mid(35, 3);
    run_meas(13, 1'b1);

    // LAUNCH follows a one-cycle SETTLE, then TMO_T cycles to DONE
    tmo_meas(1 + TMO_T);
    // inR is left high with a dead line, so SETTLE itself times out
    tmo_meas(TMO_T);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
